// File: rtl/rxcea_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : rxcea_frame_parser
//  Brief    : Parses ID/CNT/DATA/CRC frames from the UART receiver and emits
//             the command byte of each valid frame. Optional CRC-16/MODBUS
//             validation is built when RXCEA_CRC_CHECK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module rxcea_frame_parser #(
    parameter logic [15:0] DEV_ID         = 16'h0000,
    parameter int          MAX_LEN        = 4,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_flag,
    output logic [7:0] cmd,
    output logic       cmd_flag,
    output logic [7:0] cmd_len,
    output logic       frame_err
);

    localparam int                  c_TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_WIDTH-1:0] c_TO_LAST = c_TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]         c_MAX_LEN  = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_ID_1  = 3'd0,
        S_ID_2  = 3'd1,
        S_CNT_1 = 3'd2,
        S_CNT_2 = 3'd3,
        S_DATA  = 3'd4,
        S_CRC_1 = 3'd5,
        S_CRC_2 = 3'd6
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [15:0]             r_len, w_len_nxt;
    logic [7:0]              r_cnt, w_cnt_nxt;
    logic [7:0]              r_pend_cmd, w_pend_cmd_nxt;
    logic [c_TO_WIDTH-1:0]   r_tmo, w_tmo_nxt;
    logic [7:0]              w_cmd_nxt, w_cmd_len_nxt;
    logic                    w_cmd_flag_nxt, w_frame_err_nxt;
    logic [15:0]             w_len_full;
    logic                    w_crc_ok;

    assign w_len_full = {r_len[15:8], rx_data};

`ifdef RXCEA_CRC_CHECK_EN
    logic [15:0] r_crc, w_crc_nxt;
    logic [7:0]  r_crc_hi, w_crc_hi_nxt;

    // Reflected CRC-16/MODBUS, one byte per call, fully unrolled.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign w_crc_ok = ({r_crc_hi, rx_data} == r_crc);
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state    <= S_ID_1;
            r_len      <= 16'h0000;
            r_cnt      <= 8'h00;
            r_pend_cmd <= 8'h00;
            r_tmo      <= '0;
            cmd        <= 8'h00;
            cmd_len    <= 8'h00;
            cmd_flag   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RXCEA_CRC_CHECK_EN
            r_crc      <= 16'hFFFF;
            r_crc_hi   <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_cmd <= w_pend_cmd_nxt;
            r_tmo      <= w_tmo_nxt;
            cmd        <= w_cmd_nxt;
            cmd_len    <= w_cmd_len_nxt;
            cmd_flag   <= w_cmd_flag_nxt;
            frame_err  <= w_frame_err_nxt;
`ifdef RXCEA_CRC_CHECK_EN
            r_crc      <= w_crc_nxt;
            r_crc_hi   <= w_crc_hi_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_pend_cmd_nxt  = r_pend_cmd;
        w_tmo_nxt       = r_tmo;
        w_cmd_nxt       = cmd;
        w_cmd_len_nxt   = cmd_len;
        w_cmd_flag_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef RXCEA_CRC_CHECK_EN
        w_crc_nxt       = r_crc;
        w_crc_hi_nxt    = r_crc_hi;
`endif

        if (rx_data_flag) begin
            // A byte always wins over a coinciding timeout expiry.
            w_tmo_nxt = '0;
            case (r_state)
                S_ID_1: begin
                    if (rx_data == DEV_ID[15:8]) begin
                        w_state_nxt = S_ID_2;
                    end
`ifdef RXCEA_CRC_CHECK_EN
                    w_crc_nxt = (rx_data == DEV_ID[15:8]) ? crc16_upd(16'hFFFF, rx_data) : 16'hFFFF;
`endif
                end
                S_ID_2: begin
                    if (rx_data == DEV_ID[7:0]) begin
                        w_state_nxt = S_CNT_1;
`ifdef RXCEA_CRC_CHECK_EN
                        w_crc_nxt   = crc16_upd(r_crc, rx_data);
`endif
                    end else begin
                        w_state_nxt = S_ID_1;
`ifdef RXCEA_CRC_CHECK_EN
                        w_crc_nxt   = 16'hFFFF;
`endif
                    end
                end
                S_CNT_1: begin
                    w_len_nxt   = {rx_data, r_len[7:0]};
                    w_state_nxt = S_CNT_2;
`ifdef RXCEA_CRC_CHECK_EN
                    w_crc_nxt   = crc16_upd(r_crc, rx_data);
`endif
                end
                S_CNT_2: begin
                    w_len_nxt = w_len_full;
                    w_cnt_nxt = 8'h00;
                    if ((w_len_full == 16'h0000) || (w_len_full > c_MAX_LEN)) begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_ID_1;
`ifdef RXCEA_CRC_CHECK_EN
                        w_crc_nxt       = 16'hFFFF;
`endif
                    end else begin
                        w_state_nxt = S_DATA;
`ifdef RXCEA_CRC_CHECK_EN
                        w_crc_nxt   = crc16_upd(r_crc, rx_data);
`endif
                    end
                end
                S_DATA: begin
                    if (r_cnt == 8'h00) begin
                        w_pend_cmd_nxt = rx_data;
                    end
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == (r_len[7:0] - 8'd1)) begin
                        w_state_nxt = S_CRC_1;
                    end
`ifdef RXCEA_CRC_CHECK_EN
                    w_crc_nxt = crc16_upd(r_crc, rx_data);
`endif
                end
                S_CRC_1: begin
                    w_state_nxt = S_CRC_2;
`ifdef RXCEA_CRC_CHECK_EN
                    w_crc_hi_nxt = rx_data;
`endif
                end
                S_CRC_2: begin
                    w_state_nxt = S_ID_1;
                    if (w_crc_ok) begin
                        w_cmd_nxt      = r_pend_cmd;
                        w_cmd_len_nxt  = r_len[7:0];
                        w_cmd_flag_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
`ifdef RXCEA_CRC_CHECK_EN
                    w_crc_nxt = 16'hFFFF;
`endif
                end
                default: begin
                    w_state_nxt = S_ID_1;
                end
            endcase
        end else if (r_state != S_ID_1) begin
            if (r_tmo == c_TO_LAST) begin
                w_frame_err_nxt = 1'b1;
                w_state_nxt     = S_ID_1;
                w_tmo_nxt       = '0;
`ifdef RXCEA_CRC_CHECK_EN
                w_crc_nxt       = 16'hFFFF;
`endif
            end else begin
                w_tmo_nxt = r_tmo + c_TO_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rxcea_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rxcea_frame_parser
//  Brief    : Scoreboard bench for rxcea_frame_parser (CRC-aware when
//             RXCEA_CRC_CHECK_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rxcea_frame_parser;

    localparam logic [15:0] c_DEV_ID  = 16'h0000;
    localparam int          c_MAX_LEN = 4;
    localparam int          c_TMO     = 40;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] rx_data;
    logic       rx_data_flag;
    logic [7:0] cmd;
    logic       cmd_flag;
    logic [7:0] cmd_len;
    logic       frame_err;

    rxcea_frame_parser #(
        .DEV_ID        (c_DEV_ID),
        .MAX_LEN       (c_MAX_LEN),
        .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_data     (rx_data),
        .rx_data_flag(rx_data_flag),
        .cmd         (cmd),
        .cmd_flag    (cmd_flag),
        .cmd_len     (cmd_len),
        .frame_err   (frame_err)
    );

    typedef struct {
        bit         err;
        logic [7:0] cmd;
        logic [7:0] len;
        int         at;
    } ev_t;

    ev_t        r_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_len = 8'h00;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_mb(input logic [15:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    // Called at a negedge; the byte is sampled by the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_data_flag = 1'b1;
        @(negedge sys_clk);
        rx_data_flag = 1'b0;
    endtask

    task automatic expect_event(input bit err, input logic [7:0] c, input logic [7:0] l, input int dly);
        ev_t e;
        e.err = err; e.cmd = c; e.len = l; e.at = cyc + dly;
        r_q.push_back(e);
    endtask

    task automatic send_frame(input int n, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3, input bit corrupt);
        logic [7:0]  b[$];
        logic [7:0]  p[4];
        logic [15:0] c;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        b.push_back(c_DEV_ID[15:8]);
        b.push_back(c_DEV_ID[7:0]);
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        for (int i = 0; i < n; i++) b.push_back(p[i]);
        c = 16'hFFFF;
        foreach (b[i]) c = crc_mb(c, b[i]);
`ifndef RXCEA_CRC_CHECK_EN
        c = 16'h0000;
`endif
        if (corrupt) c[7:0] = ~c[7:0];
        b.push_back(c[15:8]);
        b.push_back(c[7:0]);
        for (int i = 0; i < b.size(); i++) begin
            if (i == b.size() - 1) begin
                if (corrupt) begin
                    expect_event(1'b1, m_cmd, m_len, 1);
                end else begin
                    expect_event(1'b0, p0, 8'(n), 1);
                    m_cmd = p0;
                    m_len = 8'(n);
                end
            end
            send_byte(b[i]);
        end
    endtask

    task automatic send_bad_len(input logic [15:0] len);
        send_byte(c_DEV_ID[15:8]);
        send_byte(c_DEV_ID[7:0]);
        send_byte(len[15:8]);
        expect_event(1'b1, m_cmd, m_len, 1);
        send_byte(len[7:0]);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < c_TMO + 10 && r_q.size() > 0; i++) @(negedge sys_clk);
        chk_eq(tag, r_q.size(), 0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst && (cmd_flag || frame_err)) begin
            chk_eq("excl", {31'd0, cmd_flag & frame_err}, 0);
            if (r_q.size() == 0) begin
                chk_eq("unexpected_pulse", {30'd0, cmd_flag, frame_err}, 0);
            end else begin
                ev_t e;
                e = r_q.pop_front();
                chk_eq("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                chk_eq("cmd_flag", {31'd0, cmd_flag}, {31'd0, !e.err});
                chk_eq("latency", cyc, e.at);
                chk_eq("cmd", {24'd0, cmd}, {24'd0, e.cmd});
                chk_eq("cmd_len", {24'd0, cmd_len}, {24'd0, e.len});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst      = 1'b0;
        rx_data      = 8'h00;
        rx_data_flag = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_eq("rst_cmd", {24'd0, cmd}, 0);
        chk_eq("rst_len", {24'd0, cmd_len}, 0);
        chk_eq("rst_flag", {31'd0, cmd_flag}, 0);
        chk_eq("rst_err", {31'd0, frame_err}, 0);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);

        send_frame(1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0);
        send_frame(4, 8'hA5, 8'h11, 8'h22, 8'h33, 1'b0);   // back-to-back, max length
        drain("drain_basic");
`ifdef RXCEA_CRC_CHECK_EN
        send_frame(1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1);
        drain("drain_crc_bad");
        chk_eq("cmd_hold_crc", {24'd0, cmd}, {24'd0, m_cmd});
`endif
        send_bad_len(16'd5);
        send_frame(1, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0);
        send_bad_len(16'd0);
        send_frame(2, 8'hC3, 8'h99, 8'h00, 8'h00, 1'b0);
        send_bad_len(16'h0101);
        drain("drain_len");

        send_byte(8'h00);
        send_byte(8'h07);                                   // other node
        send_frame(2, 8'h77, 8'h01, 8'h00, 8'h00, 1'b0);
        drain("drain_id");

        send_byte(c_DEV_ID[15:8]);
        send_byte(c_DEV_ID[7:0]);
        send_byte(8'h00);
        expect_event(1'b1, m_cmd, m_len, c_TMO);
        drain("drain_timeout");
        send_frame(3, 8'h42, 8'h43, 8'h44, 8'h00, 1'b0);
        drain("drain_after_tmo");

        send_byte(c_DEV_ID[15:8]);
        send_byte(c_DEV_ID[7:0]);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hAA);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk_eq("midrst_cmd", {24'd0, cmd}, 0);
        chk_eq("midrst_len", {24'd0, cmd_len}, 0);
        sys_rst = 1'b1;
        m_cmd = 8'h00;
        m_len = 8'h00;
        repeat (5) @(negedge sys_clk);
        chk_eq("postrst_cmd", {24'd0, cmd}, 0);
        send_frame(1, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("drain_final");
        repeat (5) @(negedge sys_clk);
        chk_eq("final_cmd", {24'd0, cmd}, 32'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
